// File: rtl/ir_camera_sequencer.sv
// ir_camera_sequencer
// Brings up the IR tracking camera through the shared I2C master: waits out a
// power-up delay, issues six fixed register writes, then polls periodically.
// Owns the master's command inputs and follows its ready handshake.
module ir_camera_sequencer #(
  parameter logic [6:0]  I2C_ADDR       = 7'h58,
  parameter int unsigned STARTUP_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES     = 100,
  parameter int unsigned POLL_CYCLES    = 10000,
  parameter int unsigned ACK_TIMEOUT    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         restart,
  input  logic         i2c_ready,
  output logic         i2c_start,
  output logic [6:0]   i2c_addr,
  output logic [127:0] i2c_data,
  output logic [4:0]   i2c_packets,
  output logic         i2c_rw,
  output logic         init_done,
  output logic         busy,
  output logic         error,
  output logic [2:0]   cmd_index
);

  typedef enum logic [3:0] {
    ST_STARTUP,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP,
    ST_POLL_WAIT,
    ST_IDLE,
    ST_ERROR,
    ST_DRAIN      // restart seen mid-transaction: let the master finish first
  } state_t;

  localparam logic [2:0] LAST_INIT  = 3'd5;
  localparam logic [2:0] POLL_INDEX = 3'd6;
  localparam logic [7:0] POLL_BYTE  = 8'h36;

  // Terminal counts: a state lasting N cycles exits when the counter reads N-1.
  // A zero count still spends the single entry cycle in the state.
  localparam logic [23:0] STARTUP_LAST = (STARTUP_CYCLES == 0) ? 24'd0 : 24'(STARTUP_CYCLES - 1);
  localparam logic [23:0] GAP_LAST     = (GAP_CYCLES == 0)     ? 24'd0 : 24'(GAP_CYCLES - 1);
  localparam logic [23:0] POLL_LAST    = (POLL_CYCLES == 0)    ? 24'd0 : 24'(POLL_CYCLES - 1);
  localparam logic [23:0] ACK_LAST     = (ACK_TIMEOUT == 0)    ? 24'd0 : 24'(ACK_TIMEOUT - 1);

  state_t      state, state_next;
  logic [23:0] cnt;
  logic        cnt_clear;
  logic        load_cmd;
  logic        clear_seq;
  logic        set_error;
  logic        set_init;
  logic        inc_index;
  logic        set_poll;

  // Init table: register in the upper byte, value in the lower byte.
  function automatic logic [15:0] init_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    init_entry = 16'h3001;
      3'd1:    init_entry = 16'h3008;
      3'd2:    init_entry = 16'h0690;
      3'd3:    init_entry = 16'h08C0;
      3'd4:    init_entry = 16'h1A40;
      3'd5:    init_entry = 16'h3333;
      default: init_entry = 16'h0000;
    endcase
  endfunction

  assign i2c_addr = I2C_ADDR;
  assign i2c_rw   = 1'b0;
  assign busy     = !(state == ST_GAP || state == ST_POLL_WAIT || state == ST_ERROR);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_STARTUP;
    else       state <= state_next;
  end

  // Next-state decode, start pulse and datapath control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    state_next = state;
    i2c_start  = 1'b0;
    load_cmd   = 1'b0;
    clear_seq  = 1'b0;
    set_error  = 1'b0;
    set_init   = 1'b0;
    inc_index  = 1'b0;
    set_poll   = 1'b0;

    case (state)
      ST_STARTUP:   if (cnt == STARTUP_LAST) state_next = ST_LOAD;
      ST_LOAD: begin
        load_cmd   = 1'b1;
        state_next = ST_ISSUE;
      end
      // Start is combinational on ready so it can never coincide with ready=0.
      ST_ISSUE: if (i2c_ready) begin
        i2c_start  = 1'b1;
        state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!i2c_ready) begin
          state_next = ST_WAIT_DONE;
        end else if (cnt == ACK_LAST) begin
          set_error  = 1'b1;
          state_next = ST_ERROR;
        end
      end
      ST_WAIT_DONE: if (i2c_ready) state_next = ST_GAP;
      ST_GAP: if (cnt == GAP_LAST) begin
        if (cmd_index < LAST_INIT) begin
          inc_index  = 1'b1;
          state_next = ST_LOAD;
        end else if (cmd_index == LAST_INIT) begin
          set_init   = 1'b1;
          state_next = (POLL_CYCLES == 0) ? ST_IDLE : ST_POLL_WAIT;
        end else begin
          state_next = ST_POLL_WAIT;
        end
      end
      ST_POLL_WAIT: if (cnt == POLL_LAST) begin
        set_poll   = 1'b1;
        state_next = ST_LOAD;
      end
      ST_IDLE:  state_next = ST_IDLE;
      ST_ERROR: state_next = ST_ERROR;
      ST_DRAIN: if (i2c_ready) state_next = ST_STARTUP;
      default:  state_next = ST_STARTUP;
    endcase

    // Restart overrides everything decided above, including a timeout or a
    // gap expiry in the same cycle. An open transaction is drained first.
    if (restart) begin
      i2c_start = 1'b0;
      load_cmd  = 1'b0;
      set_error = 1'b0;
      set_init  = 1'b0;
      inc_index = 1'b0;
      set_poll  = 1'b0;
      clear_seq = 1'b1;
      if (state == ST_WAIT_ACK || state == ST_WAIT_DONE) state_next = ST_DRAIN;
      else if (state != ST_DRAIN)                         state_next = ST_STARTUP;
    end
  end

  // Zero the shared counter on every state entry (and on restart, which may
  // re-enter the state it is already in).
  assign cnt_clear = (state_next != state) || restart;

  // Shared cycle counter for startup, ack timeout, gap and poll intervals.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cnt <= 24'd0;
    else if (cnt_clear) cnt <= 24'd0;
    else                cnt <= cnt + 24'd1;
  end

  // Sequence bookkeeping and the registered command payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_index   <= 3'd0;
      init_done   <= 1'b0;
      error       <= 1'b0;
      i2c_data    <= 128'd0;
      i2c_packets <= 5'd0;
    end else begin
      if (clear_seq) begin
        cmd_index <= 3'd0;
        init_done <= 1'b0;
        error     <= 1'b0;
      end else begin
        if (set_error) error     <= 1'b1;
        if (set_init)  init_done <= 1'b1;
        if (inc_index) cmd_index <= cmd_index + 3'd1;
        if (set_poll)  cmd_index <= POLL_INDEX;
      end
      // Payload only changes in LOAD, so it is stable for the whole transaction.
      if (load_cmd) begin
        if (cmd_index == POLL_INDEX) begin
          i2c_data    <= {120'd0, POLL_BYTE};
          i2c_packets <= 5'd1;
        end else begin
          i2c_data    <= {112'd0, init_entry(cmd_index)};
          i2c_packets <= 5'd2;
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_camera_sequencer.sv
// tb_ir_camera_sequencer
// Directed bench: startup, full init, polling (enabled and disabled), ack
// timeout with restart, restart mid-transaction and asynchronous reset.
// Cycle numbers: a start pulse is credited to the clock edge that samples it;
// a registered output change is credited to the edge that produces it.
module tb_ir_camera_sequencer;

  localparam int S   = 10;
  localparam int G   = 5;
  localparam int P   = 50;
  localparam int A   = 4;
  localparam int LEN = 30;

  typedef struct {
    int           cyc;
    logic [127:0] data;
    logic [4:0]   pkts;
    logic [2:0]   idx;
    logic [6:0]   addr;
    logic         rw;
    logic         init;
  } start_rec_t;

  logic clk;
  logic reset;
  logic restart;
  logic no_ack;

  logic         ready1, start1, rw1, init1, busy1, err1;
  logic [6:0]   addr1;
  logic [127:0] data1;
  logic [4:0]   pk1;
  logic [2:0]   idx1;

  logic         ready2, start2, rw2, init2, busy2, err2;
  logic [6:0]   addr2;
  logic [127:0] data2;
  logic [4:0]   pk2;
  logic [2:0]   idx2;

  int cyc;
  int n_checks;
  int n_errors;
  int dbl_starts;
  int low_starts;
  int init_rise1;
  logic prev_start1, prev_init1;
  int low_cnt1, low_cnt2;

  start_rec_t q1[$];
  start_rec_t q2[$];

  logic [15:0] table_exp [6] = '{16'h3001, 16'h3008, 16'h0690, 16'h08C0, 16'h1A40, 16'h3333};

  ir_camera_sequencer #(
    .I2C_ADDR(7'h58), .STARTUP_CYCLES(S), .GAP_CYCLES(G), .POLL_CYCLES(P), .ACK_TIMEOUT(A)
  ) u_dut (
    .clk(clk), .reset(reset), .restart(restart), .i2c_ready(ready1),
    .i2c_start(start1), .i2c_addr(addr1), .i2c_data(data1), .i2c_packets(pk1),
    .i2c_rw(rw1), .init_done(init1), .busy(busy1), .error(err1), .cmd_index(idx1)
  );

  ir_camera_sequencer #(
    .I2C_ADDR(7'h58), .STARTUP_CYCLES(S), .GAP_CYCLES(G), .POLL_CYCLES(0), .ACK_TIMEOUT(A)
  ) u_dut_nopoll (
    .clk(clk), .reset(reset), .restart(1'b0), .i2c_ready(ready2),
    .i2c_start(start2), .i2c_addr(addr2), .i2c_data(data2), .i2c_packets(pk2),
    .i2c_rw(rw2), .init_done(init2), .busy(busy2), .error(err2), .cmd_index(idx2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Master models: drop ready one cycle after a start and hold it low LEN cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ready1 <= 1'b1; low_cnt1 <= 0;
    end else if (low_cnt1 != 0) begin
      low_cnt1 <= low_cnt1 - 1;
      if (low_cnt1 == 1) ready1 <= 1'b1;
    end else if (start1 && !no_ack) begin
      ready1 <= 1'b0; low_cnt1 <= LEN;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ready2 <= 1'b1; low_cnt2 <= 0;
    end else if (low_cnt2 != 0) begin
      low_cnt2 <= low_cnt2 - 1;
      if (low_cnt2 == 1) ready2 <= 1'b1;
    end else if (start2) begin
      ready2 <= 1'b0; low_cnt2 <= LEN;
    end
  end

  function automatic start_rec_t make_rec(input int c, input logic [127:0] d, input logic [4:0] p,
                                          input logic [2:0] i, input logic [6:0] a, input logic r,
                                          input logic in);
    start_rec_t s;
    s.cyc = c; s.data = d; s.pkts = p; s.idx = i; s.addr = a; s.rw = r; s.init = in;
    return s;
  endfunction

  // Start logging and protocol invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (start1) begin
        q1.push_back(make_rec(cyc + 1, data1, pk1, idx1, addr1, rw1, init1));
        if (prev_start1) dbl_starts <= dbl_starts + 1;
        if (!ready1)     low_starts <= low_starts + 1;
      end
      if (start2) q2.push_back(make_rec(cyc + 1, data2, pk2, idx2, addr2, rw2, init2));
      if (init1 && !prev_init1) init_rise1 <= cyc;
      prev_start1 <= start1;
      prev_init1  <= init1;
    end else begin
      prev_start1 <= 1'b0;
      prev_init1  <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_q1(input int n, input int budget, input string tag);
    int k = 0;
    while (q1.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q1.size() < n) check(tag, q1.size(), n);
  endtask

  task automatic pulse_restart(output int r);
    @(negedge clk);
    restart = 1'b1;
    r = cyc + 1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    int c3;
    int k;
    n_checks = 0; n_errors = 0; dbl_starts = 0; low_starts = 0; init_rise1 = -1;
    restart = 1'b0; no_ack = 1'b0; reset = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_start",   start1, 0);
    check("rst_data",    data1, 0);
    check("rst_packets", pk1, 0);
    check("rst_rw",      rw1, 0);
    check("rst_addr",    addr1, 7'h58);
    check("rst_init",    init1, 0);
    check("rst_error",   err1, 0);
    check("rst_index",   idx1, 0);
    check("rst_busy",    busy1, 1);
    @(negedge clk);
    #2 reset = 1'b0;

    // Startup and full init table.
    wait_q1(6, 400, "init_starts_seen");
    check("first_start_cycle", q1[0].cyc, S + 2);
    check("first_packets", q1[0].pkts, 2);
    check("first_addr",    q1[0].addr, 7'h58);
    check("first_rw",      q1[0].rw, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("init_data_%0d", i), q1[i].data, {112'd0, table_exp[i]});
      check($sformatf("init_index_%0d", i), q1[i].idx, i);
      if (i > 0) check($sformatf("init_spacing_%0d", i), q1[i].cyc - q1[i-1].cyc, LEN + G + 3);
    end
    check("init_low_at_entry5", q1[5].init, 0);

    // Polling.
    wait_q1(8, 300, "poll_starts_seen");
    check("init_done_rise", init_rise1, q1[5].cyc + LEN + G + 1);
    check("init_high_at_poll", q1[6].init, 1);
    for (int i = 6; i < 8; i++) begin
      check($sformatf("poll_data_%0d", i),    q1[i].data, 128'h36);
      check($sformatf("poll_packets_%0d", i), q1[i].pkts, 1);
      check($sformatf("poll_index_%0d", i),   q1[i].idx, 6);
      check($sformatf("poll_spacing_%0d", i), q1[i].cyc - q1[i-1].cyc, LEN + G + P + 3);
    end

    // Polling disabled: nothing after entry 5.
    check("nopoll_start_count", q2.size(), 6);
    check("nopoll_init_done",   init2, 1);
    check("nopoll_busy_idle",   busy2, 1);

    // Asynchronous reset while waiting for a poll transaction to finish.
    wait_q1(9, 200, "poll3_seen");
    repeat (5) @(negedge clk);
    check("pre_reset_init",  init1, 1);
    check("pre_reset_index", idx1, 6);
    #2 reset = 1'b1;
    #1;
    check("async_rst_start", start1, 0);
    check("async_rst_init",  init1, 0);
    check("async_rst_index", idx1, 0);
    q1.delete();
    no_ack = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;

    // Acknowledge timeout.
    wait_q1(1, 100, "timeout_start_seen");
    check("rerun_first_cycle", q1[0].cyc, S + 2);
    k = 0;
    while (!err1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("error_edge", cyc, q1[0].cyc + A);
    repeat (60) @(negedge clk);
    check("no_start_in_error", q1.size(), 1);
    check("error_sticky", err1, 1);
    check("busy_in_error", busy1, 0);

    // Restart out of ERROR resumes from entry 0.
    no_ack = 1'b0;
    q1.delete();
    pulse_restart(r);
    check("restart_clears_error", err1, 0);
    check("restart_index", idx1, 0);
    wait_q1(1, 100, "restart_start_seen");
    check("restart_start_cycle", q1[0].cyc, r + S + 2);
    check("restart_start_data",  q1[0].data, 128'h3001);

    // Restart while entry 3 is in flight: drain, then rerun startup.
    wait_q1(4, 300, "entry3_seen");
    check("entry3_index", q1[3].idx, 3);
    c3 = q1[3].cyc;
    repeat (10) @(negedge clk);
    check("entry3_ready_low", ready1, 0);
    pulse_restart(r);
    check("drain_index", idx1, 0);
    check("drain_busy", busy1, 1);
    wait_q1(5, 200, "reissue_seen");
    check("reissue_cycle", q1[4].cyc, c3 + LEN + S + 3);
    check("reissue_data",  q1[4].data, 128'h3001);
    check("reissue_index", q1[4].idx, 0);

    check("double_start", dbl_starts, 0);
    check("start_while_not_ready", low_starts, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ir_camera_sequencer.md
# ir_camera_sequencer

Command sequencer that drives the shared I2C master to bring up the IR tracking camera and then keep it polled. After reset and a power-up delay, it walks a fixed table of six register writes, one I2C transaction per entry. It then issues a periodic poll write. It owns the master's `start`/`addr`/`data`/`packets`/`rw` inputs and watches its `ready` output. It sits between the top level and the I2C master.

## Interface
Parameters:
- `I2C_ADDR`, 7'h58: 7-bit camera address placed on every transaction.
- `STARTUP_CYCLES`, 1000: idle cycles after reset before the first command. Must be ≥1.
- `GAP_CYCLES`, 100: idle cycles between consecutive transactions. 0 is allowed.
- `POLL_CYCLES`, 10000: cycles between poll transactions after init. 0 disables polling.
- `ACK_TIMEOUT`, 4: cycles allowed for `i2c_ready` to fall after a start pulse.

Ports:
- `clk`, input, 1: system clock, which is also the I2C master clock.
- `reset`, input, 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `restart`, input, 1: single-cycle pulse that re-runs the init table from entry 0.
- `i2c_ready`, input, 1: from the master. High when the master is idle or stopping.
- `i2c_start`, output, 1: single-cycle start pulse to the master.
- `i2c_addr`, output, 7: always `I2C_ADDR`.
- `i2c_data`, output, 128: payload.
- `i2c_packets`, output, 5: byte count.
- `i2c_rw`, output, 1: always 0 (write).
- `init_done`, output, 1: high once all six init writes have completed.
- `busy`, output, 1: high in every state except `GAP`, `POLL_WAIT` and `ERROR`.
- `error`, output, 1: sticky; set on a start-acknowledge timeout.
- `cmd_index`, output, 3: table entry currently being issued. The poll command is 6.

## Operation
- Command table, indexed 0–5, each entry a register write with `packets`=2: (0x30,0x01), (0x30,0x08), (0x06,0x90), (0x08,0xC0), (0x1A,0x40), (0x33,0x33).
- Poll command, index 6: single byte 0x36, `packets`=1.
- Data packing: the master sends the highest used byte first.
  - 2-byte entry: `i2c_data[15:8]`=register, `i2c_data[7:0]`=value.
  - 1-byte poll: `i2c_data[7:0]`=0x36.
  - All other bits of `i2c_data` are 0.
- `i2c_data` and `i2c_packets` are registered. They are loaded in `LOAD` and held stable until the transaction completes.
- State machine transitions:
  - `STARTUP`: count `STARTUP_CYCLES`, then go to `LOAD`.
  - `LOAD`: drive the table entry for `cmd_index`, then go to `ISSUE`.
  - `ISSUE`: wait for `i2c_ready`=1. On the cycle it is seen, pulse `i2c_start` for exactly 1 cycle, then go to `WAIT_ACK`.
  - `WAIT_ACK`: wait for `i2c_ready`=0, then go to `WAIT_DONE`. If `ACK_TIMEOUT` cycles pass without it, go to `ERROR`.
  - `WAIT_DONE`: wait for `i2c_ready`=1, then go to `GAP`.
  - `GAP`: count `GAP_CYCLES`, then choose the next state:
    - `cmd_index`<5: increment `cmd_index`, go to `LOAD`.
    - `cmd_index`=5: set `init_done`. If `POLL_CYCLES`=0 go to `IDLE`; otherwise go to `POLL_WAIT`.
    - `cmd_index`=6: go to `POLL_WAIT`.
  - `POLL_WAIT`: count `POLL_CYCLES`, set `cmd_index`=6, go to `LOAD`.
  - `IDLE`: wait.
  - `ERROR`: stays there until `restart` or `reset`.
- `restart` behaviour:
  - In any state it clears `error` and `init_done`, sets `cmd_index`=0, and goes to `STARTUP`.
  - If it arrives during `WAIT_ACK` or `WAIT_DONE`, the sequencer first waits for `i2c_ready`=1 and only then goes to `STARTUP`. The master is never abandoned mid-transaction.
- Counters are 24 bits. All count parameters must be below 2^24. A counter is zeroed on every state entry.

## Timing
- Reset values:
  - `i2c_start`=0, `i2c_data`=0, `i2c_packets`=0, `i2c_rw`=0, `i2c_addr`=`I2C_ADDR`.
  - `init_done`=0, `error`=0, `cmd_index`=0, `busy`=1.
  - State is `STARTUP`.
- Reset is asynchronous in both directions (assert and release). Asserting it mid-transaction drops `i2c_start` immediately. The master is reset by the same signal.
- Cycle timing:
  - First `i2c_start` pulse: cycle `STARTUP_CYCLES`+2 after reset release.
  - `i2c_start` is never high on two consecutive cycles.
  - `i2c_start` is never asserted while `i2c_ready`=0.
  - Start-to-start spacing is transaction length + `GAP_CYCLES` + 3 cycles (ack, done and load overhead).
- `init_done` rises in the cycle that `GAP` exits after entry 5 and stays high until `restart` or `reset`.
- Simultaneous events:
  - `restart` in the same cycle as a timeout: `restart` wins and `error` stays 0.
  - `restart` in the same cycle as `GAP` expiry: `restart` wins.

## Test plan
- Startup and entry 0: reset, `STARTUP_CYCLES`=10, master model that answers `ready` low 1 cycle after start and holds it low 30 cycles -> first start at cycle 12 with `i2c_data`[15:0]=0x3001, `packets`=2, `rw`=0, `addr`=0x58.
- Full init: same setup -> six starts in table order, each spaced 30+`GAP_CYCLES`+3 cycles apart. `init_done` rises after the sixth, and `cmd_index` reads 0..5 in order.
- Polling: `POLL_CYCLES`=50 -> after init, repeated starts with `i2c_data`=0x36, `packets`=1, `cmd_index`=6, spaced every 50 + transaction + gap cycles. With `POLL_CYCLES`=0 -> no start after entry 5.
- Timeout: model never drops `ready` -> `error`=1 at `ACK_TIMEOUT` cycles after the start, then no further starts. A `restart` pulse -> `error`=0 and the sequence resumes from entry 0.
- Restart mid-transaction: pulse `restart` while `ready`=0 on entry 3 -> no start until `ready` returns high, then `STARTUP` runs and entry 0 (0x3001) is reissued.
- Async reset: assert `reset` between clock edges during `WAIT_DONE` -> `i2c_start`, `init_done` and `cmd_index` are 0 before the next clock edge.
